alu_ctl_seq: RTL and testbench
==============================

Name: alu_ctl_seq

Overview:
Registered, handshaked successor to the combinational ALU-control decoder, used as the decode stage that feeds the ALU in the pipelined/multi-cycle core.
- Maps (aluop, IR funct) to an ALU control code.
- Flags illegal encodings and keeps a sticky error bit.
- Adds a multi-cycle MUL op that back-pressures upstream for a parametrised latency.

Parameters:
ALUOP_W, 3, width of aluop input
FUNCT_W, 6, funct field width, taken from IR[FUNCT_W-1:0]
CTL_W, 4, ALU control code width (must be >= 4)
MC_LAT, 4, cycles a MUL occupies the ALU (must be >= 1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream presents aluop/ir
in_ready  out  1  block can accept; equals (state==IDLE) && rst_n
aluop  in  ALUOP_W  main-decoder ALU op class
ir  in  32  instruction word
err_clr  in  1  clears err_sticky
out_valid  out  1  one-cycle pulse: ctl/illegal/mc are new
ctl  out  CTL_W  ALU control code
illegal  out  1  current ctl came from an illegal encoding
mc  out  1  current op is multi-cycle
mc_done  out  1  one-cycle pulse: multi-cycle op completes
err_sticky  out  1  set by any illegal op, held until err_clr

Behaviour:
- Reset (async, rst_n=0) values: ctl=0, out_valid=0, illegal=0, mc=0, mc_done=0, err_sticky=0, state=IDLE, counter=0. No accept while rst_n=0. Reset mid-MUL aborts silently: no mc_done.
- Accept: a transaction is accepted on a rising edge with in_valid && in_ready. Outputs are registered, so latency is 1 cycle: out_valid is high in the cycle after the accept edge. ctl/illegal/mc hold their last values while out_valid=0.
- Codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLL=6, SRL=7, MUL=8, SLT=9.
- Decode, aluop cases:
  - aluop 0 -> ADD.
  - aluop 1 -> SUB.
  - aluop 3 -> AND.
  - aluop 4 -> OR.
  - aluop 5 -> SLT.
  - aluop 2 (R-type), by funct: funct 0x00..0x07 -> code = funct[2:0]; funct 0x18 -> MUL, mc=1; funct 0x2A -> SLT; any other funct is illegal.
  - aluop 6, 7, and any value >= 8 when ALUOP_W > 3 are illegal.
- Illegal op: still produces an out_valid pulse with ctl=ADD, illegal=1, mc=0. err_sticky sets on the same edge. If err_clr and a new illegal result land on the same edge, set wins.
- FSM IDLE/WAIT, single-cycle ops: IDLE stays IDLE, and back-to-back accepts are allowed every cycle.
- FSM, accepted MUL: counter loads MC_LAT-1, state goes to WAIT.
  - In WAIT: in_ready=0 and the counter decrements each cycle.
  - In the WAIT cycle where counter==0: mc_done=1, next state is IDLE, and in_ready is high again the following cycle.
  - Net effect: in_ready is low for exactly MC_LAT cycles after the accept edge.
  - MC_LAT=1: mc_done coincides with out_valid.
- in_valid while in_ready=0 is ignored. Upstream must hold in_valid/aluop/ir stable until accepted.
- Width rules: funct compare uses zero-extended FUNCT_W bits; ctl is zero-extended to CTL_W. The counter is $clog2(MC_LAT)+1 bits and never underflows.

Decomposition:
- Shared package alu_pkg: ALU code localparams (ALU_ADD..ALU_SLT), aluop class constants, funct constants (FN_MUL=0x18, FN_SLT=0x2A).
- One natural combinational sub-module, alu_ctl_decode: (aluop, funct) -> (ctl, illegal, mc). The wrapper holds the registers, FSM and counter.

Test Plan:
- Reset check: assert rst_n=0 for 3 cycles, release -> all outputs 0, in_ready=1.
- Back-to-back ops: accept aluop=2 with funct=0x04, then aluop=1, then aluop=4 on consecutive edges -> out_valid on 3 consecutive cycles with ctl=4, then 1, then 3; illegal=0.
- Illegal op and sticky error: aluop=2, funct=0x3F -> ctl=0, illegal=1, err_sticky=1 and stays set. err_clr pulse -> err_sticky=0. err_clr asserted on the same edge as a second illegal result -> err_sticky stays 1.
- MUL with MC_LAT=4: aluop=2, funct=0x18 -> next cycle ctl=8, mc=1; in_ready low for 4 cycles; mc_done pulses in the 4th cycle. in_valid held high throughout -> next op accepted only on the edge after in_ready returns high.
- MUL with MC_LAT=1: mc_done and out_valid appear in the same cycle; in_ready low for exactly 1 cycle.
- Reset mid-MUL: drop rst_n 2 cycles into WAIT -> immediate IDLE, no mc_done, in_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU control decode stage: ALU codes, aluop
// classes, R-type funct values and the sequencer state type.
package alu_pkg;

   // ALU control codes (zero-extended to CTL_W at the point of use)
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_NOR = 4'd5;
   localparam logic [3:0] ALU_SLL = 4'd6;
   localparam logic [3:0] ALU_SRL = 4'd7;
   localparam logic [3:0] ALU_MUL = 4'd8;
   localparam logic [3:0] ALU_SLT = 4'd9;

   // aluop classes from the main decoder
   localparam int unsigned AOP_ADD   = 0;
   localparam int unsigned AOP_SUB   = 1;
   localparam int unsigned AOP_RTYPE = 2;
   localparam int unsigned AOP_AND   = 3;
   localparam int unsigned AOP_OR    = 4;
   localparam int unsigned AOP_SLT   = 5;

   // R-type funct values; 0x00..0x07 map directly onto codes 0..7
   localparam int unsigned FN_DIRECT_LIM = 8;
   localparam int unsigned FN_MUL        = 32'h18;
   localparam int unsigned FN_SLT        = 32'h2A;

   typedef enum logic {ST_IDLE, ST_WAIT} seq_state_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational (aluop, funct) -> (ctl, illegal, mc) decoder.
module alu_ctl_decode
   import alu_pkg::*;
#(
   parameter int unsigned ALUOP_W = 3,
   parameter int unsigned FUNCT_W = 6,
   parameter int unsigned CTL_W   = 4
) (
   input  logic [ALUOP_W-1:0] aluop,
   input  logic [FUNCT_W-1:0] funct,
   output logic [CTL_W-1:0]   ctl,
   output logic               illegal,
   output logic               mc
);

   logic [31:0] aop_x;
   logic [31:0] fn_x;

   // Zero-extend both selectors so compares are width-independent
   assign aop_x = 32'(aluop);
   assign fn_x  = 32'(funct);

   // Decode; illegal encodings fall through with ctl=ADD
   always_comb begin
      ctl     = CTL_W'(ALU_ADD);
      illegal = 1'b0;
      mc      = 1'b0;
      case (aop_x)
         AOP_ADD: ctl = CTL_W'(ALU_ADD);
         AOP_SUB: ctl = CTL_W'(ALU_SUB);
         AOP_AND: ctl = CTL_W'(ALU_AND);
         AOP_OR:  ctl = CTL_W'(ALU_OR);
         AOP_SLT: ctl = CTL_W'(ALU_SLT);
         AOP_RTYPE: begin
            if (fn_x < FN_DIRECT_LIM) begin
               ctl = CTL_W'(funct[2:0]);
            end else if (fn_x == FN_MUL) begin
               ctl = CTL_W'(ALU_MUL);
               mc  = 1'b1;
            end else if (fn_x == FN_SLT) begin
               ctl = CTL_W'(ALU_SLT);
            end else begin
               illegal = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_ctl_seq.sv
// Registered, handshaked ALU control decode stage with sticky error flag
// and a multi-cycle MUL hold-off.
module alu_ctl_seq
   import alu_pkg::*;
#(
   parameter int unsigned ALUOP_W = 3,
   parameter int unsigned FUNCT_W = 6,
   parameter int unsigned CTL_W   = 4,
   parameter int unsigned MC_LAT  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ALUOP_W-1:0] aluop,
   input  logic [31:0]        ir,
   input  logic               err_clr,
   output logic               out_valid,
   output logic [CTL_W-1:0]   ctl,
   output logic               illegal,
   output logic               mc,
   output logic               mc_done,
   output logic               err_sticky
);

   localparam int unsigned CNT_W = $clog2(MC_LAT) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 1);

   seq_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CTL_W-1:0] dec_ctl;
   logic             dec_ill;
   logic             dec_mc;
   logic             ir_unused;

   // Only the funct field of the instruction word is decoded here
   assign ir_unused = ^ir[31:FUNCT_W];

   alu_ctl_decode #(
      .ALUOP_W (ALUOP_W),
      .FUNCT_W (FUNCT_W),
      .CTL_W   (CTL_W)
   ) u_dec (
      .aluop   (aluop),
      .funct   (ir[FUNCT_W-1:0]),
      .ctl     (dec_ctl),
      .illegal (dec_ill),
      .mc      (dec_mc)
   );

   // Ready only when idle and out of reset
   assign in_ready = (state == ST_IDLE) && rst_n;

   // FSM, counter and registered outputs. mc_done is registered one cycle
   // early so it is high exactly in the WAIT cycle whose counter is 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         ctl        <= '0;
         out_valid  <= 1'b0;
         illegal    <= 1'b0;
         mc         <= 1'b0;
         mc_done    <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         mc_done   <= 1'b0;
         if (err_clr) err_sticky <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  out_valid <= 1'b1;
                  ctl       <= dec_ctl;
                  illegal   <= dec_ill;
                  mc        <= dec_mc;
                  if (dec_ill) err_sticky <= 1'b1;
                  if (dec_mc) begin
                     state   <= ST_WAIT;
                     cnt     <= CNT_LOAD;
                     mc_done <= (MC_LAT == 1);
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  state <= ST_IDLE;
               end else begin
                  cnt     <= cnt - 1'b1;
                  mc_done <= (cnt == CNT_W'(1));
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_ctl_seq.sv
// Self-checking bench: two instances (MC_LAT=4 and MC_LAT=1) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_alu_ctl_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic [2:0]  aluop = '0;
   logic [31:0] ir = '0;
   logic        err_clr = 1'b0;

   logic       d_rdy  [2];
   logic       d_ov   [2];
   logic [3:0] d_ctl  [2];
   logic       d_ill  [2];
   logic       d_mc   [2];
   logic       d_done [2];
   logic       d_err  [2];

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   alu_ctl_seq #(.ALUOP_W(3), .FUNCT_W(6), .CTL_W(4), .MC_LAT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_rdy[0]),
      .aluop(aluop), .ir(ir), .err_clr(err_clr), .out_valid(d_ov[0]),
      .ctl(d_ctl[0]), .illegal(d_ill[0]), .mc(d_mc[0]), .mc_done(d_done[0]),
      .err_sticky(d_err[0])
   );

   alu_ctl_seq #(.ALUOP_W(3), .FUNCT_W(6), .CTL_W(4), .MC_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_rdy[1]),
      .aluop(aluop), .ir(ir), .err_clr(err_clr), .out_valid(d_ov[1]),
      .ctl(d_ctl[1]), .illegal(d_ill[1]), .mc(d_mc[1]), .mc_done(d_done[1]),
      .err_sticky(d_err[1])
   );

   // ---------------- behavioural model ----------------
   int unsigned lat  [2] = '{4, 1};
   int unsigned busy [2] = '{0, 0};   // cycles in_ready still stays low
   logic [3:0]  m_ctl  [2] = '{0, 0};
   bit          m_ov   [2] = '{0, 0};
   bit          m_ill  [2] = '{0, 0};
   bit          m_mc   [2] = '{0, 0};
   bit          m_done [2] = '{0, 0};
   bit          m_err  [2] = '{0, 0};

   int unsigned r_code;
   bit          r_ill, r_mc, r_acc;

   function automatic void ref_decode(input int unsigned aop, input int unsigned fn,
                                      output int unsigned code, output bit ill, output bit mcf);
      code = 0; ill = 0; mcf = 0;
      if      (aop == 0) code = 0;
      else if (aop == 1) code = 1;
      else if (aop == 3) code = 2;
      else if (aop == 4) code = 3;
      else if (aop == 5) code = 9;
      else if (aop == 2) begin
         if      (fn < 8)     code = fn;
         else if (fn == 24)   begin code = 8; mcf = 1; end
         else if (fn == 42)   code = 9;
         else                 ill = 1;
      end else ill = 1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            busy[k] = 0; m_ctl[k] = 0; m_ov[k] = 0; m_ill[k] = 0;
            m_mc[k] = 0; m_done[k] = 0; m_err[k] = 0;
         end else begin
            r_acc = in_valid && (busy[k] == 0);
            m_ov[k] = r_acc;
            if (err_clr) m_err[k] = 0;
            if (r_acc) begin
               ref_decode(32'(aluop), 32'(ir[5:0]), r_code, r_ill, r_mc);
               m_ctl[k] = r_code[3:0];
               m_ill[k] = r_ill;
               m_mc[k]  = r_mc;
               if (r_ill) m_err[k] = 1;
               busy[k] = r_mc ? lat[k] : 0;
            end else if (busy[k] > 0) begin
               busy[k] = busy[k] - 1;
            end
            m_done[k] = (busy[k] == 1);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %0h exp %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("rdy%0d", k),  32'(d_rdy[k]),  32'(rst_n && (busy[k] == 0)));
            chk($sformatf("ov%0d", k),   32'(d_ov[k]),   32'(m_ov[k]));
            chk($sformatf("ctl%0d", k),  32'(d_ctl[k]),  32'(m_ctl[k]));
            chk($sformatf("ill%0d", k),  32'(d_ill[k]),  32'(m_ill[k]));
            chk($sformatf("mc%0d", k),   32'(d_mc[k]),   32'(m_mc[k]));
            chk($sformatf("done%0d", k), 32'(d_done[k]), 32'(m_done[k]));
            chk($sformatf("err%0d", k),  32'(d_err[k]),  32'(m_err[k]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input bit v, input logic [2:0] a, input logic [5:0] fn);
      in_valid = v;
      aluop    = a;
      ir       = {26'h155_5555, fn};
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int unsigned c;
      bit pi;
      bit pm;
      int unsigned sel;
      logic [5:0] fn;

      // model pins
      ref_decode(2, 32'h04, c, pi, pm); chk("ref_r04", c, 4);
      ref_decode(2, 32'h18, c, pi, pm); chk("ref_mul", {c[30:0], pm}, {31'd8, 1'b1});
      ref_decode(2, 32'h3F, c, pi, pm); chk("ref_ill", {c[30:0], pi}, {31'd0, 1'b1});
      ref_decode(5, 0, c, pi, pm);      chk("ref_slt", c, 9);

      // reset for 3 cycles
      #2 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("rst_rdy", 32'(d_rdy[0]), 1);
      chk("rst_ctl", 32'(d_ctl[0]), 0);
      chk("rst_err", 32'(d_err[0]), 0);

      // back-to-back single-cycle ops
      set_op(1, 3'd2, 6'h04); step();
      chk("b2b_ctl4", 32'(d_ctl[0]), 4);
      chk("b2b_ov4",  32'(d_ov[0]), 1);
      set_op(1, 3'd1, 6'h00); step();
      chk("b2b_ctl1", 32'(d_ctl[0]), 1);
      set_op(1, 3'd4, 6'h00); step();
      chk("b2b_ctl3", 32'(d_ctl[0]), 3);
      chk("b2b_ill",  32'(d_ill[0]), 0);
      set_op(0, 3'd0, 6'h00); step();
      chk("b2b_idle", 32'(d_ov[0]), 0);

      // illegal op and sticky error
      set_op(1, 3'd2, 6'h3F); step();
      chk("ill_flag", 32'(d_ill[0]), 1);
      chk("ill_ctl",  32'(d_ctl[0]), 0);
      chk("ill_err",  32'(d_err[0]), 1);
      set_op(0, 3'd0, 6'h00); step(); step();
      chk("ill_hold", 32'(d_err[0]), 1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("ill_clr", 32'(d_err[0]), 0);
      set_op(1, 3'd7, 6'h00); step();
      chk("ill_aop7", 32'(d_err[0]), 1);
      err_clr = 1'b1; set_op(1, 3'd6, 6'h00); step();
      err_clr = 1'b0; set_op(0, 3'd0, 6'h00);
      chk("ill_setwins", 32'(d_err[0]), 1);
      err_clr = 1'b1; step(); err_clr = 1'b0;

      // MUL with in_valid held high afterwards
      set_op(1, 3'd2, 6'h18); step();
      chk("mul_ctl", 32'(d_ctl[0]), 8);
      chk("mul_mc",  32'(d_mc[0]), 1);
      chk("mul_rdy1", 32'(d_rdy[0]), 0);
      chk("mul1_done", 32'(d_done[1]), 1);
      chk("mul1_ov",   32'(d_ov[1]), 1);
      set_op(1, 3'd1, 6'h00);
      step(); chk("mul_rdy2", 32'(d_rdy[0]), 0);
      chk("mul1_rdy", 32'(d_rdy[1]), 1);
      step(); chk("mul_rdy3", 32'(d_rdy[0]), 0);
      step(); chk("mul_rdy4", 32'(d_rdy[0]), 0);
      chk("mul_done", 32'(d_done[0]), 1);
      step(); chk("mul_back", 32'(d_rdy[0]), 1);
      chk("mul_noacc", 32'(d_ov[0]), 0);
      step(); chk("mul_next", 32'(d_ov[0]), 1);
      chk("mul_next_ctl", 32'(d_ctl[0]), 1);
      set_op(0, 3'd0, 6'h00); step();

      // reset mid-MUL
      set_op(1, 3'd2, 6'h18); step();
      set_op(0, 3'd0, 6'h00); step(); step();
      rst_n = 1'b0; #1;
      chk("midrst_done", 32'(d_done[0]), 0);
      chk("midrst_rdy",  32'(d_rdy[0]), 0);
      step(); rst_n = 1'b1; #1;
      chk("midrst_back", 32'(d_rdy[0]), 1);
      step(); step();
      chk("midrst_nodone", 32'(d_done[0]), 0);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         sel = $urandom_range(0, 5);
         case (sel)
            0: fn = 6'h18;
            1: fn = 6'h2A;
            2, 3: fn = 6'($urandom_range(0, 7));
            default: fn = 6'($urandom_range(0, 63));
         endcase
         in_valid = ($urandom_range(0, 3) != 0);
         aluop    = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'($urandom_range(0, 7));
         ir       = $urandom;
         ir[5:0]  = fn;
         err_clr  = ($urandom_range(0, 9) == 0);
         rst_n    = ($urandom_range(0, 149) != 0);
         step();
      end
      rst_n = 1'b1;
      in_valid = 1'b0;
      err_clr = 1'b0;
      step(); step();

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
